alu_scheduler: RTL and testbench
================================

# alu_scheduler

Shares one combinational `ALU` instance between two requesters. Uses round-robin arbitration and valid/ready handshakes on every port. Each accepted operation is evaluated in the cycle it is accepted. The result, flags and requester id are captured in a single output register, which is held until the consumer takes it. It sits between the two operand-producing units (e.g. the execute stage and the address unit) and the shared ALU datapath.

## Interface
- `n`, default 32: operand/result width, passed to the `ALU` instance
- `clk` input 1: clock, all state updates on rising edge
- `reset` input 1: synchronous, active-high
- `req0_valid` input 1: requester 0 presents an operation
- `req0_ready` output 1: requester 0 operation accepted this cycle when high with `req0_valid`
- `req0_a` input n: operand A, two's complement
- `req0_b` input n: operand B, two's complement
- `req0_cmd` input 3: 0 ADD, 1 SUB, 2 SLT, 3–6 logic ops per ALU, 7 reserved
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_cmd`: same as requester 0
- `rsp_valid` output 1: output register holds a result
- `rsp_ready` input 1: consumer takes the result when high with `rsp_valid`
- `rsp_id` output 1: requester that issued the result
- `rsp_result` output n: ALU result
- `rsp_carryout`, `rsp_zero`, `rsp_overflow` output 1 each: ALU flags
- `rsp_err` output 1: command 7 was issued

## Operation
- Output-register FSM has two states:
  - EMPTY → FULL on accept.
  - FULL → EMPTY on `rsp_ready` with no new accept.
  - FULL → FULL when `rsp_ready` and an accept happen in the same cycle.
- `can_accept = !rsp_valid || rsp_ready`. The output drains and reloads in the same cycle, so full throughput is one op/cycle.
- Grant:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not named by `last_grant` is granted.
  - `last_grant` updates only on an actual accept.
- `reqX_ready = can_accept && grant==X`. At most one ready is high per cycle.
- Readies depend combinationally on both valids. Requesters must not make valid depend on ready.
- A requester holding valid without acceptance must keep its operands and command stable.
- The mux feeds the granted operands to the `ALU`. The ALU's `result/carryout/zero/overflow` are registered unmodified.
- Command 7: register result 0, all flags 0, `rsp_err=1`. Otherwise `rsp_err=0`.
- Reset values:
  - `rsp_valid=0`, `rsp_result=0`, all flags 0, `rsp_id=0`, `rsp_err=0`.
  - `last_grant=1`, so requester 0 wins the first contention.
- Reset mid-operation: a held result is discarded and nothing is accepted in the reset cycle. Requesters must re-present after reset.

## Timing
- Accept at edge t → `rsp_*` valid from t (registered output, visible after edge t), i.e. latency 1 cycle from the accept cycle.
- Output holds all `rsp_*` stable while `rsp_valid && !rsp_ready`. Both readies are low during that stall.
- Back-to-back contention alternates grants every accept: 0,1,0,1…
- Single requester streaming gets every cycle, with no bubble when `rsp_ready` is held high.
- Critical path: valid → grant → mux → ALU (ripple through n bits) → output register D.

## Structure
- Shared package/include holds:
  - command constants `CMD_ADD=0`, `CMD_SUB=1`, `CMD_SLT=2`, …, `CMD_RSVD=7`
  - FSM state constants `EMPTY`, `FULL`
- Instantiates the existing `ALU #(.n(n))` unmodified.
- One natural sub-module, `rr_arbiter2`: two valids, `last_grant` register, enable input, one-hot grant output.

## Test plan
(All with n=4.)
- **Single ADD:** req0 ADD a=0110, b=0100, `rsp_ready=1`.
  - Next cycle: `rsp_result=1010`, carry 0, zero 0, overflow 1, `rsp_id=0`.
- **Wrap ADD:** req1 ADD a=1111, b=0001.
  - `rsp_result=0000`, carry 1, zero 1, overflow 0, `rsp_id=1`.
- **Contention:** both valid for 4 cycles.
  - req0 SUB a=0111, b=1010.
  - req1 SLT a=1100, b=1001.
  - Accept order is 0,1,0,1.
  - req0 results are `1101` with overflow 1.
  - req1 results are `0000` with zero 1.
- **Backpressure:** `rsp_ready=0` for 3 cycles after a result.
  - `rsp_*` stay stable.
  - Both readies stay 0.
  - Release `rsp_ready` → the next op is accepted in that same cycle.
- **Reserved command:** req0 cmd=7, any operands.
  - `rsp_err=1`, result 0000, all flags 0.
- **Reset:** assert `reset` while FULL with req1 valid.
  - Next cycle: `rsp_valid=0` and no accept.
  - After release, contention grants req0 first.

Source files
------------

// File: rtl/alu_scheduler_pkg.sv
// Shared definitions for the two-requester ALU scheduler.
//   - 3-bit command encodings understood by the shared ALU
//   - output-register FSM state type
//   - helper to recognise the reserved command
package alu_scheduler_pkg;

  localparam logic [2:0] CMD_ADD  = 3'd0;
  localparam logic [2:0] CMD_SUB  = 3'd1;
  localparam logic [2:0] CMD_SLT  = 3'd2;
  localparam logic [2:0] CMD_AND  = 3'd3;
  localparam logic [2:0] CMD_OR   = 3'd4;
  localparam logic [2:0] CMD_XOR  = 3'd5;
  localparam logic [2:0] CMD_NOR  = 3'd6;
  localparam logic [2:0] CMD_RSVD = 3'd7;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  function automatic logic is_reserved(input logic [2:0] cmd);
    return cmd == CMD_RSVD;
  endfunction

endpackage

// File: rtl/ALU.sv
// Combinational n-bit ALU shared by the scheduler.
// Ports:
//   a, b      : operands (two's complement)
//   cmd       : 0 ADD, 1 SUB, 2 SLT, 3 AND, 4 OR, 5 XOR, 6 NOR, 7 none
//   result    : operation result
//   carryout  : carry out of ADD; no-borrow (a >= b unsigned) for SUB; 0 otherwise
//   zero      : result == 0
//   overflow  : signed overflow for ADD/SUB; 0 otherwise
module ALU #(
  parameter int n = 32
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic [2:0]   cmd,
  output logic [n-1:0] result,
  output logic         carryout,
  output logic         zero,
  output logic         overflow
);

  logic [n:0] w_sum;
  logic [n:0] w_diff;
  logic       w_ovf_add;
  logic       w_ovf_sub;
  logic       w_lt;

  assign w_sum     = {1'b0, a} + {1'b0, b};
  // Subtraction as a + ~b + 1 so the carry out means "no borrow".
  assign w_diff    = {1'b0, a} + {1'b0, ~b} + {{n{1'b0}}, 1'b1};
  assign w_ovf_add = (a[n-1] == b[n-1]) && (w_sum[n-1] != a[n-1]);
  assign w_ovf_sub = (a[n-1] != b[n-1]) && (w_diff[n-1] != a[n-1]);
  assign w_lt      = $signed(a) < $signed(b);

  always_comb begin
    result   = '0;
    carryout = 1'b0;
    overflow = 1'b0;
    case (cmd)
      3'd0: begin result = w_sum[n-1:0];  carryout = w_sum[n];  overflow = w_ovf_add; end
      3'd1: begin result = w_diff[n-1:0]; carryout = w_diff[n]; overflow = w_ovf_sub; end
      3'd2: result = {{(n-1){1'b0}}, w_lt};
      3'd3: result = a & b;
      3'd4: result = a | b;
      3'd5: result = a ^ b;
      3'd6: result = ~(a | b);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   i_valid    : request lines {req1, req0}
//   i_en       : an accept can happen this cycle; last grant advances only then
//   o_grant    : one-hot grant {req1, req0}, all-zero when nobody requests
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_valid,
  input  logic       i_en,
  output logic [1:0] o_grant
);

  // Index of the requester granted on the most recent accept. Reset to 1
  // so requester 0 wins the first contention.
  logic r_last_grant;

  always_comb begin
    o_grant = 2'b00;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = r_last_grant ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= 1'b1;
    end else if (i_en && (o_grant != 2'b00)) begin
      r_last_grant <= o_grant[1];
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one combinational ALU between two requesters. A round-robin grant
// picks the operation, it is evaluated the cycle it is accepted, and the
// result/flags/id are captured in a single output register held until taken.
//
// Handshake: a transfer happens on a port in any cycle where both its valid
// and ready are high at the rising clock edge. Readies depend combinationally
// on the valids; a requester must not make valid depend on ready and must hold
// its operands/command stable while valid is high and not yet accepted.
//
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   reqX_valid/ready/a/b/cmd    : requester X operation channel (X = 0, 1)
//   rsp_valid/ready             : output-register handshake
//   rsp_id                      : requester that issued the held result
//   rsp_result, rsp_carryout, rsp_zero, rsp_overflow : registered ALU outputs
//   rsp_err                     : the held result came from reserved command 7
//   o_dbg_state                 : output-register FSM state
module alu_scheduler
  import alu_scheduler_pkg::*;
#(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [n-1:0] req0_a,
  input  logic [n-1:0] req0_b,
  input  logic [2:0]   req0_cmd,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [n-1:0] req1_a,
  input  logic [n-1:0] req1_b,
  input  logic [2:0]   req1_cmd,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [n-1:0] rsp_result,
  output logic         rsp_carryout,
  output logic         rsp_zero,
  output logic         rsp_overflow,
  output logic         rsp_err,
  output state_t       o_dbg_state
);

  state_t       r_state;
  state_t       w_state_next;
  logic         w_can_accept;
  logic         w_en;
  logic [1:0]   w_grant;
  logic         w_accept;
  logic [n-1:0] w_a;
  logic [n-1:0] w_b;
  logic [2:0]   w_cmd;
  logic [n-1:0] w_alu_result;
  logic         w_alu_carry;
  logic         w_alu_zero;
  logic         w_alu_ovf;

  logic         r_rsp_id;
  logic [n-1:0] r_rsp_result;
  logic         r_rsp_carry;
  logic         r_rsp_zero;
  logic         r_rsp_ovf;
  logic         r_rsp_err;

  // The register may drain and reload in the same cycle; nothing is
  // accepted while reset is asserted.
  assign w_can_accept = !rsp_valid || rsp_ready;
  assign w_en         = w_can_accept && !reset;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .i_valid ({req1_valid, req0_valid}),
    .i_en    (w_en),
    .o_grant (w_grant)
  );

  assign req0_ready = w_en && w_grant[0];
  assign req1_ready = w_en && w_grant[1];
  assign w_accept   = req0_ready || req1_ready;

  assign w_a   = w_grant[1] ? req1_a   : req0_a;
  assign w_b   = w_grant[1] ? req1_b   : req0_b;
  assign w_cmd = w_grant[1] ? req1_cmd : req0_cmd;

  ALU #(.n(n)) u_alu (
    .a        (w_a),
    .b        (w_b),
    .cmd      (w_cmd),
    .result   (w_alu_result),
    .carryout (w_alu_carry),
    .zero     (w_alu_zero),
    .overflow (w_alu_ovf)
  );

  // Output-register FSM: state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= EMPTY;
    else       r_state <= w_state_next;
  end

  // Output-register FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      EMPTY:   if (w_accept) w_state_next = FULL;
      FULL:    if (!w_accept && rsp_ready) w_state_next = EMPTY;
      default: w_state_next = EMPTY;
    endcase
  end

  // Output-register FSM: outputs
  always_comb begin
    rsp_valid   = (r_state == FULL);
    o_dbg_state = r_state;
  end

  // Result capture; reserved command zeroes result and flags and flags err.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_carry  <= 1'b0;
      r_rsp_zero   <= 1'b0;
      r_rsp_ovf    <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else if (w_accept) begin
      r_rsp_id <= w_grant[1];
      if (is_reserved(w_cmd)) begin
        r_rsp_result <= '0;
        r_rsp_carry  <= 1'b0;
        r_rsp_zero   <= 1'b0;
        r_rsp_ovf    <= 1'b0;
        r_rsp_err    <= 1'b1;
      end else begin
        r_rsp_result <= w_alu_result;
        r_rsp_carry  <= w_alu_carry;
        r_rsp_zero   <= w_alu_zero;
        r_rsp_ovf    <= w_alu_ovf;
        r_rsp_err    <= 1'b0;
      end
    end
  end

  assign rsp_id       = r_rsp_id;
  assign rsp_result   = r_rsp_result;
  assign rsp_carryout = r_rsp_carry;
  assign rsp_zero     = r_rsp_zero;
  assign rsp_overflow = r_rsp_ovf;
  assign rsp_err      = r_rsp_err;

endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler with n=4. Responses are packed as
// {id, err, carry, zero, overflow, result[3:0]}.
module tb_alu_scheduler;
  import alu_scheduler_pkg::*;

  localparam int N = 4;
  localparam int W = 9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_cmd, req1_cmd;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [N-1:0] rsp_result;
  logic         rsp_carryout, rsp_zero, rsp_overflow, rsp_err;
  state_t       dbg_state;
  logic [W-1:0] rsp_pk;

  assign rsp_pk = {rsp_id, rsp_err, rsp_carryout, rsp_zero, rsp_overflow, rsp_result};

  alu_scheduler #(.n(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_cmd     (req0_cmd),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_cmd     (req1_cmd),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_carryout (rsp_carryout),
    .rsp_zero     (rsp_zero),
    .rsp_overflow (rsp_overflow),
    .rsp_err      (rsp_err),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic         last_g;      // requester that won the previous accept
  logic         m_acc0, m_acc1;
  int           n_vec = 0;
  int           n_err = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU from plain integer arithmetic.
  function automatic logic [W-1:0] ref_op(input logic id, input logic [2:0] cmd,
                                          input logic [N-1:0] a, input logic [N-1:0] b);
    int ua, ub, sa, sb, t, st;
    logic [N-1:0] r;
    logic c, z, o, e;
    ua = int'(a); ub = int'(b);
    sa = a[N-1] ? ua - 16 : ua;
    sb = b[N-1] ? ub - 16 : ub;
    r = '0; c = 1'b0; o = 1'b0; e = 1'b0;
    case (cmd)
      3'd0: begin t = ua + ub; r = 4'(t % 16); c = (t >= 16);
                  st = sa + sb; o = (st > 7) || (st < -8); end
      3'd1: begin t = ua - ub; r = 4'((t + 16) % 16); c = (ua >= ub);
                  st = sa - sb; o = (st > 7) || (st < -8); end
      3'd2: r = (sa < sb) ? 4'd1 : 4'd0;
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = ~(a | b);
      default: e = 1'b1;
    endcase
    z = !e && (r == '0);
    return {id, e, c, z, o, r};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_req(input int id, input logic v, input logic [2:0] cmd,
                         input logic [N-1:0] a, input logic [N-1:0] b);
    if (id == 0) begin req0_valid = v; req0_cmd = cmd; req0_a = a; req0_b = b; end
    else         begin req1_valid = v; req1_cmd = cmd; req1_a = a; req1_b = b; end
  endtask

  // One clock cycle; called just after a negedge with inputs already driven.
  // Checks readies, advances the model on the edge, checks the output register.
  task automatic step();
    logic can, g0, g1, cons;
    #1;
    can = (exp_q.size() == 0) || rsp_ready;
    if (reset) begin
      g0 = 1'b0; g1 = 1'b0;
    end else if (req0_valid && req1_valid) begin
      g0 = last_g; g1 = !last_g;
    end else begin
      g0 = req0_valid; g1 = req1_valid;
    end
    m_acc0 = can && g0;
    m_acc1 = can && g1;
    check("req0_ready", {8'd0, req0_ready}, {8'd0, m_acc0});
    check("req1_ready", {8'd0, req1_ready}, {8'd0, m_acc1});
    cons = (exp_q.size() != 0) && rsp_ready;
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
      last_g = 1'b1;
    end else begin
      if (cons) void'(exp_q.pop_front());
      if (m_acc0) begin exp_q.push_back(ref_op(1'b0, req0_cmd, req0_a, req0_b)); last_g = 1'b0; end
      else if (m_acc1) begin exp_q.push_back(ref_op(1'b1, req1_cmd, req1_a, req1_b)); last_g = 1'b1; end
    end
    @(negedge clk);
    check("rsp_valid", {8'd0, rsp_valid}, {8'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) check("rsp_fields", rsp_pk, exp_q[0]);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         id;
    logic [2:0]   cmd;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // exp = {id, err, c, z, o, result}
    tbl[0]  = '{1'b0, 3'd0, 4'b0110, 4'b0100, 9'b0_0_0_0_1_1010};
    tbl[1]  = '{1'b1, 3'd0, 4'b1111, 4'b0001, 9'b1_0_1_1_0_0000};
    tbl[2]  = '{1'b0, 3'd1, 4'b0111, 4'b1010, 9'b0_0_0_0_1_1101};
    tbl[3]  = '{1'b1, 3'd2, 4'b1100, 4'b1001, 9'b1_0_0_1_0_0000};
    tbl[4]  = '{1'b0, 3'd7, 4'b0101, 4'b0011, 9'b0_1_0_0_0_0000};
    tbl[5]  = '{1'b1, 3'd3, 4'b1100, 4'b1010, 9'b1_0_0_0_0_1000};
    tbl[6]  = '{1'b0, 3'd4, 4'b1100, 4'b1010, 9'b0_0_0_0_0_1110};
    tbl[7]  = '{1'b1, 3'd5, 4'b1100, 4'b1010, 9'b1_0_0_0_0_0110};
    tbl[8]  = '{1'b0, 3'd6, 4'b1100, 4'b1010, 9'b0_0_0_0_0_0001};
    tbl[9]  = '{1'b1, 3'd1, 4'b0011, 4'b0011, 9'b1_0_1_1_0_0000};
    tbl[10] = '{1'b0, 3'd2, 4'b1001, 4'b1100, 9'b0_0_0_0_0_0001};
    tbl[11] = '{1'b1, 3'd1, 4'b1000, 4'b0001, 9'b1_0_1_0_1_0111};

    reset = 1'b1;
    rsp_ready = 1'b0;
    last_g = 1'b1;
    set_req(0, 1'b0, 3'd0, 4'd0, 4'd0);
    set_req(1, 1'b0, 3'd0, 4'd0, 4'd0);
    @(negedge clk);
    step();
    check("reset_state", {rsp_valid, rsp_pk[W-2:0]}, '0);
    reset = 1'b0;

    // Table: one op at a time, consumer always ready.
    rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      set_req(int'(tbl[i].id), 1'b1, tbl[i].cmd, tbl[i].a, tbl[i].b);
      step();
      set_req(int'(tbl[i].id), 1'b0, tbl[i].cmd, tbl[i].a, tbl[i].b);
      check($sformatf("tbl%0d", i), rsp_pk, tbl[i].exp);
    end
    step();

    // Contention after reset: grants 0,1,0,1.
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_req(0, 1'b1, 3'd1, 4'b0111, 4'b1010);
    set_req(1, 1'b1, 3'd2, 4'b1100, 4'b1001);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("contend%0d", i), rsp_pk,
            (i % 2 == 0) ? 9'b0_0_0_0_1_1101 : 9'b1_0_0_1_0_0000);
    end

    // Backpressure: hold result for 3 cycles, then drain and reload together.
    set_req(1, 1'b0, 3'd0, 4'b1111, 4'b0001);
    set_req(0, 1'b1, 3'd0, 4'b0110, 4'b0100);
    step();
    rsp_ready = 1'b0;
    set_req(1, 1'b1, 3'd0, 4'b1111, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall%0d", i), rsp_pk, 9'b0_0_0_0_1_1010);
    end
    rsp_ready = 1'b1;
    step();
    check("stall_release", rsp_pk, 9'b1_0_1_1_0_0000);

    // Reset while FULL with req1 valid.
    rsp_ready = 1'b0;
    set_req(0, 1'b0, 3'd0, 4'b0110, 4'b0100);
    reset = 1'b1;
    step();
    check("reset_full", {rsp_valid, rsp_pk[W-2:0]}, '0);
    reset = 1'b0;
    rsp_ready = 1'b1;
    set_req(0, 1'b1, 3'd1, 4'b0111, 4'b1010);
    set_req(1, 1'b1, 3'd2, 4'b1100, 4'b1001);
    step();
    check("post_reset_grant", rsp_pk, 9'b0_0_0_0_1_1101);

    // Randomized traffic against the model; operands only change after accept.
    for (int c = 0; c < 600; c++) begin
      if (!req0_valid || m_acc0) begin
        set_req(0, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end
      if (!req1_valid || m_acc1) begin
        set_req(1, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end
      rsp_ready = $urandom_range(0, 3) != 0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
